// File: rtl/rriscv_pkg.sv
// Shared types and constants for the data-memory controller.
// Holds the access-size and FSM-state encodings plus the alignment fault check.
package rriscv_pkg;

  localparam int XLEN          = 32;
  localparam int DATA_MEM_SIZE = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  typedef logic [XLEN-1:0] data_mem_type_t [DATA_MEM_SIZE];

  // The 2'b11 size encoding is reserved and always faults.
  function automatic logic access_fault(mem_size_e size, logic [1:0] lane);
    logic f;
    case (size)
      MEM_B:   f = 1'b0;
      MEM_H:   f = lane[0];
      MEM_W:   f = (lane != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the data-memory controller.
// Signal names carry the controller's direction suffixes.
interface dmem_ctrl_if #(
  parameter int XLEN = rriscv_pkg::XLEN
);
  import rriscv_pkg::*;

  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  mem_size_e       req_size_i;
  logic            req_unsigned_i;
  logic [XLEN-1:0] req_addr_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane alignment: write enables, store-data replication and load extraction.
// Purely combinational; the lane is the low two address bits.
module dmem_align
  import rriscv_pkg::*;
#(
  parameter int XLEN = rriscv_pkg::XLEN
) (
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    shifted = rword_i >> {lane_i, 3'b000};
    case (size_i)
      MEM_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                             : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        be_o    = 4'b0011 << lane_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                             : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      MEM_W: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: resettable word array with byte/half/word access
// and a fixed, parameterised response latency.
//
// state | meaning
// IDLE  | no request outstanding, ready for a new one
// WAIT  | request captured, counting down remaining latency
// RESP  | response presented; may accept the next request
module dmem_ctrl
  import rriscv_pkg::*;
#(
  parameter int XLEN    = rriscv_pkg::XLEN,
  parameter int DEPTH   = rriscv_pkg::DATA_MEM_SIZE,
  parameter int LATENCY = 1
) (
  input logic        clk_i,
  input logic        rst_n_i,
  dmem_ctrl_if.slave bus
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (XLEN != 32) begin : g_xlen_chk
    $error("dmem_ctrl: XLEN must be 32");
  end
  if ((LATENCY < 1) || (LATENCY > 4)) begin : g_lat_chk
    $error("dmem_ctrl: LATENCY must be within 1..4");
  end

  dmem_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic            ready;
  logic            accept;
  logic            oob;
  logic            req_err;
  logic [AW-1:0]   widx;
  logic [XLEN-1:0] rword;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep;
  logic [XLEN-1:0] ld_data;

  assign widx    = bus.req_addr_i[AW+1:2];
  assign oob     = (bus.req_addr_i[XLEN-1:2] >= (XLEN-2)'(DEPTH));
  assign req_err = oob | access_fault(bus.req_size_i, bus.req_addr_i[1:0]);
  // Out-of-range indices are never used: req_err masks both read and write.
  assign rword   = oob ? '0 : mem_q[widx];

  dmem_align #(.XLEN(XLEN)) u_align (
    .size_i     (bus.req_size_i),
    .unsigned_i (bus.req_unsigned_i),
    .lane_i     (bus.req_addr_i[1:0]),
    .wdata_i    (bus.req_wdata_i),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_rep),
    .rdata_o    (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = RESP;
      end
      RESP: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    accept = bus.req_valid_i & ready;
    if (accept) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d   = CW'(LATENCY - 1);
      err_d   = req_err;
      rdata_d = (req_err | bus.req_we_i) ? '0 : ld_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept && bus.req_we_i && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter XLEN, default rriscv_pkg::XLEN (32), data word width in bits; SHALL be 32.
REQ-002 Parameter DEPTH, default rriscv_pkg::DATA_MEM_SIZE, number of XLEN-bit words.
REQ-003 Parameter LATENCY, default 1, cycles from request acceptance to response; legal range 1..4.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 req_valid_i  input  1  request present.
REQ-007 req_ready_o  output  1  controller can accept a request this cycle.
REQ-008 req_we_i  input  1  1 = store, 0 = load.
REQ-009 req_size_i  input  2  mem_size_e access size: byte, half or word.
REQ-010 req_unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-011 req_addr_i  input  XLEN  byte address.
REQ-012 req_wdata_i  input  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-013 rsp_valid_o  output  1  one-cycle response pulse.
REQ-014 rsp_rdata_o  output  XLEN  load data, extended to XLEN; 0 for stores and errors.
REQ-015 rsp_err_o  output  1  request was misaligned or out of range; valid with rsp_valid_o.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1.
REQ-017 FSM states SHALL be IDLE, WAIT and RESP; req_ready_o SHALL be 1 in IDLE and RESP and 0 in WAIT.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY = 1; otherwise it SHALL go to WAIT and load the counter with LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-020 rsp_valid_o SHALL be 1 only in RESP, exactly LATENCY cycles after acceptance; rsp_rdata_o and rsp_err_o SHALL be held stable for that cycle.
REQ-021 From RESP, the FSM SHALL accept a new request (back-to-back) or return to IDLE; one request is outstanding at most.
REQ-022 Word index = addr[XLEN-1:2]; byte lane = addr[1:0].
REQ-023 Error conditions SHALL be: half access with addr[0] = 1; word access with addr[1:0] != 0; word index >= DEPTH; req_size_i = 2'b11.
REQ-024 An erroring request SHALL leave memory unchanged and SHALL respond with rsp_err_o = 1 and rsp_rdata_o = 0.
REQ-025 A store SHALL be written on its acceptance edge, updating only the addressed byte lanes (SB 1 lane, SH 2 lanes, SW 4 lanes).
REQ-026 A load SHALL capture memory on its acceptance edge and SHALL see every store accepted on an earlier edge.
REQ-027 Load data SHALL be lane-shifted to bit 0, then sign- or zero-extended from bit 7 or 15 according to size and req_unsigned_i.
REQ-028 req_* inputs SHALL be ignored when the request is not accepted; no request SHALL be lost or duplicated.

Reset
REQ-029 While rst_n_i = 0: FSM = IDLE, counter = 0, every memory word = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0.
REQ-030 Reset mid-operation SHALL discard the outstanding request with no response; a store already accepted SHALL be cleared by the memory reset.
REQ-031 req_ready_o SHALL be 1 on the first cycle after reset is released.

Structure
REQ-032 rriscv_pkg SHALL hold XLEN, DATA_MEM_SIZE, mem_size_e (MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10), dmem_state_e and data_mem_type_t.
REQ-033 Byte-lane write-enable generation, store data replication and load extraction/extension SHALL be in one combinational sub-module, dmem_align.
REQ-034 The counter SHALL be $clog2(LATENCY+1) bits wide; LATENCY outside 1..4 SHALL fail elaboration.

Verification
REQ-035 LATENCY = 1: SW 0xDEADBEEF at 0x10, then LW 0x10 -> rsp_rdata_o = 0xDEADBEEF one cycle after acceptance, rsp_err_o = 0.
REQ-036 After REQ-035 data: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-037 SB 0x55 at 0x11, then LW 0x10 -> 0xDEAD55EF (single byte lane written).
REQ-038 LH 0x11, SW 0x12 and LW DEPTH*4 -> rsp_err_o = 1 and rsp_rdata_o = 0 for each; a following LW 0x10 returns unchanged data.
REQ-039 LATENCY = 3 with req_valid_i held high: req_ready_o pattern 1,0,0,1; responses every 3 cycles, in order, no requests dropped.
REQ-040 Assert rst_n_i = 0 while in WAIT -> no rsp_valid_o pulse; after release, LW 0x10 -> rsp_rdata_o = 0.
